// File: rtl/imm_encoder_pkg.sv
// Shared immediate-format and error codes, plus the decode used to recover
// a 32-bit immediate from packed instruction bits [31:7].
package imm_encoder_pkg;

    typedef enum logic [2:0] {
        SRC_I = 3'b000,
        SRC_S = 3'b001,
        SRC_B = 3'b010,
        SRC_J = 3'b011,
        SRC_U = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_RANGE    = 2'b01,
        ERR_MISALIGN = 2'b10,
        ERR_ILLEGAL  = 2'b11
    } imm_err_e;

    localparam int unsigned IMM_W   = 32;
    localparam int unsigned INSTR_W = 25;
    localparam int unsigned CNT_W   = 8;

    // Sign_Extend: instr[24:0] holds instruction bits [31:7].
    function automatic logic [IMM_W-1:0] sign_extend(input logic [INSTR_W-1:0] instr,
                                                     input logic [2:0]         src);
        logic [IMM_W-1:0] v;
        v = '0;
        case (src)
            SRC_I: v = {{20{instr[24]}}, instr[24:13]};
            SRC_S: v = {{20{instr[24]}}, instr[24:18], instr[4:0]};
            SRC_B: v = {{19{instr[24]}}, instr[24], instr[0], instr[23:18], instr[4:1], 1'b0};
            SRC_J: v = {{11{instr[24]}}, instr[24], instr[12:5], instr[13], instr[23:14], 1'b0};
            SRC_U: v = {instr[24:5], 12'b0};
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// Combinational packer: places a signed immediate into instruction bits [31:7]
// and reports legality. Output bits are zero whenever an error is flagged.
module imm_pack
    import imm_encoder_pkg::*;
(
    input  logic [2:0]         src_i,
    input  logic [IMM_W-1:0]   imm_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [1:0]         err_o
);

    logic [INSTR_W-1:0] packed_v;
    imm_err_e           err_v;
    logic               fit_12, fit_13, fit_21, u_low_zero;

    // A value fits N signed bits when every bit above N-1 matches the sign bit.
    assign fit_12     = (&imm_i[31:11]) | ~(|imm_i[31:11]);
    assign fit_13     = (&imm_i[31:12]) | ~(|imm_i[31:12]);
    assign fit_21     = (&imm_i[31:20]) | ~(|imm_i[31:20]);
    assign u_low_zero = ~(|imm_i[11:0]);

    always_comb begin
        packed_v = '0;
        err_v    = ERR_OK;
        case (src_i)
            SRC_I: begin
                packed_v[24:13] = imm_i[11:0];
                if (!fit_12) err_v = ERR_RANGE;
            end
            SRC_S: begin
                packed_v[24:18] = imm_i[11:5];
                packed_v[4:0]   = imm_i[4:0];
                if (!fit_12) err_v = ERR_RANGE;
            end
            SRC_B: begin
                packed_v[24]    = imm_i[12];
                packed_v[23:18] = imm_i[10:5];
                packed_v[4:1]   = imm_i[4:1];
                packed_v[0]     = imm_i[11];
                if (imm_i[0])     err_v = ERR_MISALIGN;
                else if (!fit_13) err_v = ERR_RANGE;
            end
            SRC_J: begin
                packed_v[24]    = imm_i[20];
                packed_v[23:14] = imm_i[10:1];
                packed_v[13]    = imm_i[11];
                packed_v[12:5]  = imm_i[19:12];
                if (imm_i[0])     err_v = ERR_MISALIGN;
                else if (!fit_21) err_v = ERR_RANGE;
            end
            SRC_U: begin
                packed_v[24:5] = imm_i[31:12];
                if (!u_low_zero) err_v = ERR_RANGE;
            end
            default: err_v = ERR_ILLEGAL;
        endcase
    end

    assign instr_o = (err_v == ERR_OK) ? packed_v : '0;
    assign err_o   = err_v;

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready immediate encoder: stage 1 holds the request while
// imm_pack checks it, stage 2 holds the packed result; errors are counted.
module imm_encoder
    import imm_encoder_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         ImmSrc,
    input  logic [IMM_W-1:0]   imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [1:0]         err,
    output logic [CNT_W-1:0]   err_cnt,
    input  logic               cnt_clr
);

    logic               s1_valid_q, s1_valid_d;
    logic [2:0]         s1_src_q, s1_src_d;
    logic [IMM_W-1:0]   s1_imm_q, s1_imm_d;
    logic               s2_valid_q, s2_valid_d;
    logic [INSTR_W-1:0] s2_instr_q, s2_instr_d;
    logic [1:0]         s2_err_q, s2_err_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic [INSTR_W-1:0] pk_instr;
    logic [1:0]         pk_err;
    logic               s2_adv, accept, out_hs;

    imm_pack u_pack (
        .src_i   (s1_src_q),
        .imm_i   (s1_imm_q),
        .instr_o (pk_instr),
        .err_o   (pk_err)
    );

    always_comb begin
        s2_adv   = !s2_valid_q || out_ready;
        in_ready = !s1_valid_q || s2_adv;
        accept   = in_valid && in_ready;
        out_hs   = s2_valid_q && out_ready;

        s1_valid_d = s1_valid_q;
        s1_src_d   = s1_src_q;
        s1_imm_d   = s1_imm_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_src_d   = ImmSrc;
            s1_imm_d   = imm;
        end else if (s1_valid_q && s2_adv) begin
            s1_valid_d = 1'b0;
        end

        s2_valid_d = s2_valid_q;
        s2_instr_d = s2_instr_q;
        s2_err_d   = s2_err_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_instr_d = pk_instr;
                s2_err_d   = pk_err;
            end
        end

        // Clear wins over a same-cycle errored handshake.
        err_cnt_d = err_cnt_q;
        if (cnt_clr) begin
            err_cnt_d = '0;
        end else if (out_hs && (s2_err_q != ERR_OK) && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_src_q   <= '0;
            s1_imm_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_instr_q <= '0;
            s2_err_q   <= '0;
            err_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_src_q   <= s1_src_d;
            s1_imm_q   <= s1_imm_d;
            s2_valid_q <= s2_valid_d;
            s2_instr_q <= s2_instr_d;
            s2_err_q   <= s2_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign instr     = s2_instr_q;
    assign err       = s2_err_q;
    assign err_cnt   = err_cnt_q;

endmodule
